// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder.
// Holds funct3 width codes and the responder FSM state type.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESPOND
    } mem_resp_state_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational RV32I byte/half/word lane steering for loads and stores.
// Ports: addr_lo, funct3, store, raw, wdata -> byte_en, merged, load_val, bad.
module load_store_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic        store,
    input  logic [31:0] raw,
    input  logic [31:0] wdata,
    output logic [3:0]  byte_en,
    output logic [31:0] merged,
    output logic [31:0] load_val,
    output logic        bad
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] wrep;

    always_comb begin
        lane_b   = raw[{addr_lo, 3'b000} +: 8];
        lane_h   = addr_lo[1] ? raw[31:16] : raw[15:0];
        byte_en  = 4'b0000;
        wrep     = wdata;
        load_val = '0;
        bad      = 1'b0;
        case (funct3)
            F3_B: begin
                byte_en  = 4'b0001 << addr_lo;
                wrep     = {4{wdata[7:0]}};
                load_val = {{24{lane_b[7]}}, lane_b};
            end
            F3_H: begin
                byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
                wrep     = {2{wdata[15:0]}};
                load_val = {{16{lane_h[15]}}, lane_h};
                bad      = addr_lo[0];
            end
            F3_W: begin
                byte_en  = 4'b1111;
                load_val = raw;
                bad      = |addr_lo;
            end
            // Unsigned widths exist only for loads.
            F3_BU: begin
                load_val = {24'h0, lane_b};
                bad      = store;
            end
            F3_HU: begin
                load_val = {16'h0, lane_h};
                bad      = store | addr_lo[0];
            end
            default: bad = 1'b1;
        endcase
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = byte_en[i] ? wrep[8*i +: 8]
                                          : raw[8*i +: 8];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts held read/write enables, performs the access
// after LATENCY cycles and pulses a done with rdata/access_err.
// Ports: clk, reset, mem_read_enable, mem_write_enable, addr, wdata, funct3
//        -> rdata, mem_read_done, mem_write_done, access_err.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_enable,
    input  logic        mem_write_enable,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic        mem_read_done,
    output logic        mem_write_done,
    output logic        access_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    mem_resp_state_t state, state_n;
    logic [CNT_W-1:0] count, count_n;
    logic             armed, armed_n;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;
    logic        write_q;
    logic        both_q;
    logic [31:0] rdata_hold;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic [31:0]      raw;
    logic [3:0]       byte_en;
    logic [31:0]      merged;
    logic [31:0]      load_val;
    logic             bad;
    logic             err;
    logic             accept;
    logic             respond;
    logic [31:0]      rdata_new;

    assign idx      = addr_q[IDX_W+1:2];
    assign in_range = {2'b00, addr_q[31:2]} < 32'(DEPTH_WORDS);
    assign raw      = in_range ? mem[idx] : '0;
    assign err      = both_q | bad | ~in_range;
    assign respond  = (state == RESPOND);

    assign accept = (state == IDLE) & armed &
                    (mem_read_enable | mem_write_enable);

    load_store_align u_align (
        .addr_lo  (addr_q[1:0]),
        .funct3   (f3_q),
        .store    (write_q),
        .raw      (raw),
        .wdata    (wdata_q),
        .byte_en  (byte_en),
        .merged   (merged),
        .load_val (load_val),
        .bad      (bad)
    );

    always_comb begin
        state_n = state;
        count_n = count;
        armed_n = armed;
        if (!mem_read_enable && !mem_write_enable) armed_n = 1'b1;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_n = RESPOND;
                    end else begin
                        state_n = ACCESS;
                        count_n = CNT_W'(LATENCY - 1);
                    end
                end
            end
            ACCESS: begin
                if (count == CNT_W'(1)) state_n = RESPOND;
                else                    count_n = count - 1'b1;
            end
            RESPOND: begin
                // A master still holding its enable must drop it first.
                state_n = IDLE;
                armed_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            armed <= 1'b1;
        end else begin
            state <= state_n;
            count <= count_n;
            armed <= armed_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            write_q <= 1'b0;
            both_q  <= 1'b0;
        end else if (accept) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            f3_q    <= funct3;
            write_q <= mem_write_enable & ~mem_read_enable;
            both_q  <= mem_write_enable & mem_read_enable;
        end
    end

    // rdata shows the new load value during RESPOND and holds it afterwards.
    assign rdata_new = err ? '0 : load_val;
    assign rdata     = (respond && !write_q) ? rdata_new : rdata_hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                    rdata_hold <= '0;
        else if (respond && !write_q) rdata_hold <= rdata_new;
    end

    always_ff @(posedge clk) begin
        if (respond && write_q && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[idx][8*i +: 8] <= merged[8*i +: 8];
            end
        end
    end

    assign mem_read_done  = respond & ~write_q;
    assign mem_write_done = respond & write_q;
    assign access_err     = respond & err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (LATENCY=2).
// Each task drives one scenario and checks its own results.
module tb_data_mem_responder;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic [31:0] rdata;
    logic        mem_read_done;
    logic        mem_write_done;
    logic        access_err;

    int tests = 0;
    int fails = 0;

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .addr             (addr),
        .wdata            (wdata),
        .funct3           (funct3),
        .rdata            (rdata),
        .mem_read_done    (mem_read_done),
        .mem_write_done   (mem_write_done),
        .access_err       (access_err)
    );

    always #5 clk = ~clk;

    // Called at a negedge; returns cycles to done (-1 on timeout).
    task automatic do_req(
        input  logic        rd,
        input  logic        wr,
        input  logic [31:0] a,
        input  logic [31:0] wd,
        input  logic [2:0]  f3,
        output int          cyc,
        output logic        rd_d,
        output logic        wr_d,
        output logic        err,
        output logic [31:0] data
    );
        mem_read_enable  = rd;
        mem_write_enable = wr;
        addr   = a;
        wdata  = wd;
        funct3 = f3;
        cyc  = -1;
        rd_d = 1'b0;
        wr_d = 1'b0;
        err  = 1'b0;
        data = '0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (mem_read_done || mem_write_done) begin
                cyc  = i;
                rd_d = mem_read_done;
                wr_d = mem_write_done;
                err  = access_err;
                data = rdata;
                break;
            end
        end
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        tests++;
        if (rdata !== 32'h0 || mem_read_done !== 1'b0 ||
            mem_write_done !== 1'b0 || access_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_out rdata=%h rd=%b wr=%b err=%b want 0",
                     rdata, mem_read_done, mem_write_done, access_err);
        end
    endtask

    task automatic test_word_rw;
        int c; logic r, w, e; logic [31:0] d;
        do_req(0, 1, 32'h10, 32'hDEADBEEF, F3_W, c, r, w, e, d);
        tests++;
        if (c !== 2 || r !== 0 || w !== 1 || e !== 0) begin
            fails++;
            $display("FAIL sw cyc=%0d rd=%b wr=%b err=%b want 2/0/1/0",
                     c, r, w, e);
        end
        do_req(1, 0, 32'h10, 32'h0, F3_W, c, r, w, e, d);
        tests++;
        if (c !== 2 || r !== 1 || w !== 0 || e !== 0) begin
            fails++;
            $display("FAIL lw_done cyc=%0d rd=%b wr=%b err=%b want 2/1/0/0",
                     c, r, w, e);
        end
        tests++;
        if (d !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL lw_data got=%h want=deadbeef", d);
        end
        tests++;
        if (rdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL rdata_hold got=%h want=deadbeef", rdata);
        end
    endtask

    task automatic test_subword_loads;
        int c; logic r, w, e; logic [31:0] d;
        do_req(1, 0, 32'h13, 32'h0, F3_B, c, r, w, e, d);
        tests++;
        if (d !== 32'hFFFFFFDE || e !== 0) begin
            fails++;
            $display("FAIL lb got=%h err=%b want=ffffffde", d, e);
        end
        do_req(1, 0, 32'h13, 32'h0, F3_BU, c, r, w, e, d);
        tests++;
        if (d !== 32'h000000DE || e !== 0) begin
            fails++;
            $display("FAIL lbu got=%h err=%b want=000000de", d, e);
        end
        do_req(1, 0, 32'h12, 32'h0, F3_H, c, r, w, e, d);
        tests++;
        if (d !== 32'hFFFFDEAD || e !== 0) begin
            fails++;
            $display("FAIL lh got=%h err=%b want=ffffdead", d, e);
        end
        do_req(1, 0, 32'h10, 32'h0, F3_HU, c, r, w, e, d);
        tests++;
        if (d !== 32'h0000BEEF || e !== 0) begin
            fails++;
            $display("FAIL lhu got=%h err=%b want=0000beef", d, e);
        end
    endtask

    task automatic test_store_byte;
        int c; logic r, w, e; logic [31:0] d;
        do_req(0, 1, 32'h11, 32'h000000AA, F3_B, c, r, w, e, d);
        tests++;
        if (w !== 1 || e !== 0 || rdata !== 32'h0000BEEF) begin
            fails++;
            $display("FAIL sb wr=%b err=%b rdata=%h want 1/0/0000beef",
                     w, e, rdata);
        end
        do_req(1, 0, 32'h10, 32'h0, F3_W, c, r, w, e, d);
        tests++;
        if (d !== 32'hDEADAAEF) begin
            fails++;
            $display("FAIL sb_merge got=%h want=deadaaef", d);
        end
    endtask

    task automatic test_errors;
        int c; logic r, w, e; logic [31:0] d;
        do_req(1, 0, 32'h12, 32'h0, F3_W, c, r, w, e, d);
        tests++;
        if (c !== 2 || r !== 1 || e !== 1 || d !== 32'h0) begin
            fails++;
            $display("FAIL lw_misal cyc=%0d rd=%b err=%b d=%h want 2/1/1/0",
                     c, r, e, d);
        end
        do_req(0, 1, 32'h11, 32'h00001234, F3_H, c, r, w, e, d);
        tests++;
        if (c !== 2 || w !== 1 || e !== 1) begin
            fails++;
            $display("FAIL sh_misal cyc=%0d wr=%b err=%b want 2/1/1",
                     c, w, e);
        end
        do_req(0, 1, 32'h10, 32'h55555555, F3_BU, c, r, w, e, d);
        tests++;
        if (w !== 1 || e !== 1) begin
            fails++;
            $display("FAIL st_illegal wr=%b err=%b want 1/1", w, e);
        end
        do_req(1, 0, 32'h10, 32'h0, F3_W, c, r, w, e, d);
        tests++;
        if (d !== 32'hDEADAAEF || e !== 0) begin
            fails++;
            $display("FAIL err_nowrite got=%h err=%b want=deadaaef", d, e);
        end
        do_req(1, 0, 32'h1000, 32'h0, F3_W, c, r, w, e, d);
        tests++;
        if (c !== 2 || r !== 1 || e !== 1 || d !== 32'h0) begin
            fails++;
            $display("FAIL oor cyc=%0d rd=%b err=%b d=%h want 2/1/1/0",
                     c, r, e, d);
        end
        do_req(1, 0, 32'h10, 32'h0, 3'b011, c, r, w, e, d);
        tests++;
        if (r !== 1 || e !== 1 || d !== 32'h0) begin
            fails++;
            $display("FAIL ld_illegal rd=%b err=%b d=%h want 1/1/0",
                     r, e, d);
        end
        do_req(1, 1, 32'h10, 32'h0, F3_W, c, r, w, e, d);
        tests++;
        if (r !== 1 || w !== 0 || e !== 1) begin
            fails++;
            $display("FAIL both_en rd=%b wr=%b err=%b want 1/0/1", r, w, e);
        end
        do_req(1, 0, 32'h10, 32'h0, F3_W, c, r, w, e, d);
        tests++;
        if (d !== 32'hDEADAAEF) begin
            fails++;
            $display("FAIL both_nowrite got=%h want=deadaaef", d);
        end
    endtask

    task automatic test_hold_enable;
        int c1; int c2; int extra;
        logic [31:0] d;
        mem_read_enable = 1'b1;
        addr   = 32'h10;
        funct3 = F3_W;
        c1 = -1;
        d  = '0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (mem_read_done) begin c1 = i; d = rdata; break; end
        end
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_read_done || mem_write_done) extra++;
        end
        tests++;
        if (c1 !== 2 || extra !== 0 || d !== 32'hDEADAAEF) begin
            fails++;
            $display("FAIL hold cyc=%0d extra=%0d d=%h want 2/0/deadaaef",
                     c1, extra, d);
        end
        mem_read_enable = 1'b0;
        @(negedge clk);
        mem_read_enable = 1'b1;
        c2 = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (mem_read_done) begin c2 = i; break; end
        end
        tests++;
        if (c2 !== 2) begin
            fails++;
            $display("FAIL rearm cyc=%0d want 2", c2);
        end
        mem_read_enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int c; int dn; logic r, w, e; logic [31:0] d;
        mem_write_enable = 1'b1;
        addr   = 32'h10;
        wdata  = 32'h12345678;
        funct3 = F3_W;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        mem_write_enable = 1'b0;
        #1;
        tests++;
        if (rdata !== 32'h0 || mem_read_done !== 1'b0 ||
            mem_write_done !== 1'b0 || access_err !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid rdata=%h rd=%b wr=%b err=%b want 0",
                     rdata, mem_read_done, mem_write_done, access_err);
        end
        @(negedge clk);
        reset = 1'b0;
        dn = 0;
        repeat (4) begin
            @(negedge clk);
            if (mem_read_done || mem_write_done) dn++;
        end
        tests++;
        if (dn !== 0) begin
            fails++;
            $display("FAIL rst_nodone dones=%0d want 0", dn);
        end
        do_req(1, 0, 32'h10, 32'h0, F3_W, c, r, w, e, d);
        tests++;
        if (d !== 32'hDEADAAEF) begin
            fails++;
            $display("FAIL rst_discard got=%h want=deadaaef", d);
        end
    endtask

    initial begin
        reset = 1'b1;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        addr   = '0;
        wdata  = '0;
        funct3 = '0;
        repeat (2) @(negedge clk);
        test_reset;
        reset = 1'b0;
        @(negedge clk);
        test_word_rw;
        test_subword_loads;
        test_store_byte;
        test_errors;
        test_hold_enable;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
